// File: rtl/spi_master_tx.sv
// SPI initiator, mode 0 (CPOL=0, CPHA=0).
// Sends one register write per request as three MSB-first bytes:
// {3'b000, addr[4:0]}, data[15:8], data[7:0]. Every output comes
// straight from a flop.
module spi_master_tx #(
    parameter int CLK_DIV = 4    // clk_in cycles per SCLK half-period, 2..255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [4:0]  addr_in,
    input  logic [15:0] data_in,
    output logic        done_out,
    output logic        busy_out,
    output logic        spi_cs_out,
    output logic        spi_sclk_out,
    output logic        spi_mosi_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'd23;

    state_t      state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [23:0] shift_reg, shift_next;
    logic        cs_reg, cs_next;
    logic        sclk_reg, sclk_next;
    logic        ready_reg, ready_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        div_last;

    // MOSI is the top bit of the shift register. The register is cleared
    // whenever chip select is released, so the line rests low between
    // frames and holds the last bit through the HOLD phase.
    assign spi_mosi_out  = shift_reg[23];
    assign spi_cs_out    = cs_reg;
    assign spi_sclk_out  = sclk_reg;
    assign req_ready_out = ready_reg;
    assign busy_out      = busy_reg;
    assign done_out      = done_reg;

    assign div_last = (div_reg == DIV_LAST);

    // State and output registers with synchronous reset; a reset
    // mid-frame abandons the transfer without a done pulse.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg   <= ST_IDLE;
            div_reg     <= 8'd0;
            bit_cnt_reg <= 5'd0;
            shift_reg   <= 24'd0;
            cs_reg      <= 1'b1;
            sclk_reg    <= 1'b0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            cs_reg      <= cs_next;
            sclk_reg    <= sclk_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Next-state and next-output logic. Each phase lasts CLK_DIV cycles,
    // and the divider restarts at every phase change.
    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        cs_next      = cs_reg;
        sclk_next    = sclk_reg;
        ready_next   = ready_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                div_next     = 8'd0;
                bit_cnt_next = 5'd0;
                if (req_valid_in && ready_reg) begin
                    shift_next = {3'b000, addr_in, data_in};
                    cs_next    = 1'b0;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                    state_next = ST_LOW;
                end
            end

            ST_LOW: begin
                if (div_last) begin
                    div_next   = 8'd0;
                    sclk_next  = 1'b1;
                    state_next = ST_HIGH;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end

            ST_HIGH: begin
                if (div_last) begin
                    div_next  = 8'd0;
                    sclk_next = 1'b0;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = ST_HOLD;
                    end else begin
                        // Falling SCLK edge: present the next bit.
                        shift_next   = {shift_reg[22:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        state_next   = ST_LOW;
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end

            ST_HOLD: begin
                if (div_last) begin
                    div_next   = 8'd0;
                    cs_next    = 1'b1;
                    shift_next = 24'd0;
                    state_next = ST_GAP;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end

            ST_GAP: begin
                if (div_last) begin
                    div_next   = 8'd0;
                    done_next  = 1'b1;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV=4 and CLK_DIV=2),
// a bus monitor acting as the receiving slave, and scenario tasks
// comparing against frames and timings computed from the wire format.
module tb_spi_master_tx;

    localparam int NCH  = 2;
    localparam int BITS = 24;

    logic clk  = 1'b0;
    logic srst = 1'b1;

    logic        req_valid [NCH];
    logic [4:0]  addr      [NCH];
    logic [15:0] data      [NCH];
    logic        ready     [NCH];
    logic        done      [NCH];
    logic        busy      [NCH];
    logic        cs        [NCH];
    logic        sclk      [NCH];
    logic        mosi      [NCH];

    int div_of [NCH] = '{4, 2};

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_dut
            localparam int D = (gi == 0) ? 4 : 2;
            spi_master_tx #(.CLK_DIV(D)) u_dut (
                .clk_in        (clk),
                .reset_in      (srst),
                .req_valid_in  (req_valid[gi]),
                .req_ready_out (ready[gi]),
                .addr_in       (addr[gi]),
                .data_in       (data[gi]),
                .done_out      (done[gi]),
                .busy_out      (busy[gi]),
                .spi_cs_out    (cs[gi]),
                .spi_sclk_out  (sclk[gi]),
                .spi_mosi_out  (mosi[gi])
            );
        end
    endgenerate

    // ---------------- bus monitor (slave side) ----------------
    int          cyc = 0;
    logic        p_cs   [NCH] = '{1'b1, 1'b1};
    logic        p_sclk [NCH] = '{1'b0, 1'b0};
    logic        p_mosi [NCH] = '{1'b0, 1'b0};
    logic [23:0] cap        [NCH] = '{24'd0, 24'd0};
    int          edges      [NCH] = '{0, 0};
    int          low_cnt    [NCH] = '{0, 0};
    int          high_cnt   [NCH] = '{0, 0};
    int          last_gap   [NCH] = '{0, 0};
    int          since_rise [NCH] = '{0, 0};
    int          last_rise  [NCH] = '{0, 0};
    int          period     [NCH] = '{0, 0};
    int          frames     [NCH] = '{0, 0};
    int          done_cnt   [NCH] = '{0, 0};
    int          done_delay [NCH] = '{0, 0};
    int          mosi_bad   [NCH] = '{0, 0};
    int          busy_bad   [NCH] = '{0, 0};
    int          done_bad   [NCH] = '{0, 0};
    logic [23:0] frame_log  [NCH][64];
    int          edge_log   [NCH][64];
    int          low_log    [NCH][64];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            // chip select falling: a new frame starts
            if (p_cs[i] === 1'b1 && cs[i] === 1'b0) begin
                last_gap[i]  = high_cnt[i];
                cap[i]       = 24'd0;
                edges[i]     = 0;
                low_cnt[i]   = 1;
                last_rise[i] = 0;
            end else if (cs[i] === 1'b0) begin
                low_cnt[i]++;
            end
            // slave samples MOSI on SCLK rising
            if (sclk[i] === 1'b1 && p_sclk[i] === 1'b0) begin
                cap[i] = {cap[i][22:0], mosi[i]};
                edges[i]++;
                if (last_rise[i] != 0) period[i] = cyc - last_rise[i];
                last_rise[i] = cyc;
            end
            // MOSI may only move with SCLK falling or with a CS change
            if (mosi[i] !== p_mosi[i] && !(p_sclk[i] === 1'b1 && sclk[i] === 1'b0)
                && cs[i] === p_cs[i])
                mosi_bad[i]++;
            if (cs[i] === 1'b0 && busy[i] !== 1'b1) busy_bad[i]++;
            // chip select rising: frame ends
            if (p_cs[i] === 1'b0 && cs[i] === 1'b1) begin
                frame_log[i][frames[i] % 64] = cap[i];
                edge_log[i][frames[i] % 64]  = edges[i];
                low_log[i][frames[i] % 64]   = low_cnt[i];
                frames[i]++;
                high_cnt[i]   = 1;
                since_rise[i] = 0;
            end else begin
                if (cs[i] === 1'b1) high_cnt[i]++;
                since_rise[i]++;
            end
            if (done[i] === 1'b1) begin
                done_cnt[i]++;
                done_delay[i] = since_rise[i];
                if (busy[i] !== 1'b0 || ready[i] !== 1'b1) done_bad[i]++;
            end
            p_cs[i]   = cs[i];
            p_sclk[i] = sclk[i];
            p_mosi[i] = mosi[i];
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [23:0] model_frame(input logic [4:0] a, input logic [15:0] d);
        return {3'b000, a, d};
    endfunction

    function automatic int model_cs_low(input int dv);
        return (2 * BITS + 1) * dv;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [4:0] a, input logic [15:0] d);
        int n;
        n = 0;
        tick();
        while (ready[i] !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            compared++;
            failed++;
            $display("FAIL send_timeout ch%0d: ready=%b after %0d cycles, required 1", i, ready[i], n);
        end
        addr[i]      = a;
        data[i]      = d;
        req_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_frames(input int i, input int target);
        int n;
        n = 0;
        while (frames[i] < target && n < 2000) begin
            tick();
            n++;
        end
        if (frames[i] < target) begin
            compared++;
            failed++;
            $display("FAIL frame_timeout ch%0d: frames=%0d, required %0d", i, frames[i], target);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        srst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NCH; i++) begin
            compared++; if (cs[i] !== 1'b1)    begin failed++; $display("FAIL reset_cs ch%0d: got %b want 1", i, cs[i]); end
            compared++; if (sclk[i] !== 1'b0)  begin failed++; $display("FAIL reset_sclk ch%0d: got %b want 0", i, sclk[i]); end
            compared++; if (mosi[i] !== 1'b0)  begin failed++; $display("FAIL reset_mosi ch%0d: got %b want 0", i, mosi[i]); end
            compared++; if (ready[i] !== 1'b1) begin failed++; $display("FAIL reset_ready ch%0d: got %b want 1", i, ready[i]); end
            compared++; if (busy[i] !== 1'b0)  begin failed++; $display("FAIL reset_busy ch%0d: got %b want 0", i, busy[i]); end
            compared++; if (done[i] !== 1'b0)  begin failed++; $display("FAIL reset_done ch%0d: got %b want 0", i, done[i]); end
        end
        srst = 1'b0;
        tick();
    endtask

    // One complete write with full frame and timing checks.
    task automatic test_frame(input int i, input logic [4:0] a, input logic [15:0] d);
        int f0, d0, mb0, bb0, db0, dv, slot;
        logic [23:0] exp;
        dv  = div_of[i];
        f0  = frames[i];
        d0  = done_cnt[i];
        mb0 = mosi_bad[i];
        bb0 = busy_bad[i];
        db0 = done_bad[i];
        exp = model_frame(a, d);
        send(i, a, d);
        wait_frames(i, f0 + 1);
        repeat (dv + 3) tick();
        slot = f0 % 64;
        $display("ch%0d div=%0d addr=%h data=%h frame=%h edges=%0d cs_low=%0d",
                 i, dv, a, d, frame_log[i][slot], edge_log[i][slot], low_log[i][slot]);
        compared++; if (frame_log[i][slot] !== exp) begin failed++; $display("FAIL frame ch%0d: got %h want %h", i, frame_log[i][slot], exp); end
        compared++; if (edge_log[i][slot] != BITS) begin failed++; $display("FAIL sclk_edges ch%0d: got %0d want %0d", i, edge_log[i][slot], BITS); end
        compared++; if (low_log[i][slot] != model_cs_low(dv)) begin failed++; $display("FAIL cs_low ch%0d: got %0d want %0d", i, low_log[i][slot], model_cs_low(dv)); end
        compared++; if (period[i] != 2 * dv) begin failed++; $display("FAIL sclk_period ch%0d: got %0d want %0d", i, period[i], 2 * dv); end
        compared++; if (done_cnt[i] != d0 + 1) begin failed++; $display("FAIL done_count ch%0d: got %0d want %0d", i, done_cnt[i], d0 + 1); end
        compared++; if (done_delay[i] != dv) begin failed++; $display("FAIL done_delay ch%0d: got %0d want %0d", i, done_delay[i], dv); end
        compared++; if (mosi_bad[i] != mb0) begin failed++; $display("FAIL mosi_timing ch%0d: got %0d bad changes want 0", i, mosi_bad[i] - mb0); end
        compared++; if (busy_bad[i] != bb0) begin failed++; $display("FAIL busy_span ch%0d: got %0d low-busy cycles want 0", i, busy_bad[i] - bb0); end
        compared++; if (done_bad[i] != db0) begin failed++; $display("FAIL done_flags ch%0d: got %0d bad done cycles want 0", i, done_bad[i] - db0); end
    endtask

    task automatic test_single();
        test_frame(0, 5'h05, 16'hA5C3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++)
            test_frame(0, 5'($urandom_range(0, 31)), 16'($urandom()));
    endtask

    task automatic test_back_to_back();
        int f0, d0, n, dv;
        dv = div_of[0];
        f0 = frames[0];
        d0 = done_cnt[0];
        send(0, 5'h1F, 16'hFFFF);
        req_valid[0] = 1'b1;
        addr[0]      = 5'h00;
        data[0]      = 16'h0000;
        n = 0;
        while (done[0] !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        compared++; if (ready[0] !== 1'b1) begin failed++; $display("FAIL b2b_ready_at_done: got %b want 1", ready[0]); end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_frames(0, f0 + 2);
        repeat (dv + 3) tick();
        $display("ch0 back-to-back frames=%h,%h gap=%0d", frame_log[0][f0 % 64], frame_log[0][(f0 + 1) % 64], last_gap[0]);
        compared++; if (frame_log[0][f0 % 64] !== model_frame(5'h1F, 16'hFFFF)) begin failed++; $display("FAIL b2b_frame1: got %h want %h", frame_log[0][f0 % 64], model_frame(5'h1F, 16'hFFFF)); end
        compared++; if (frame_log[0][(f0 + 1) % 64] !== model_frame(5'h00, 16'h0000)) begin failed++; $display("FAIL b2b_frame2: got %h want %h", frame_log[0][(f0 + 1) % 64], 24'h0); end
        compared++; if (last_gap[0] != dv + 1) begin failed++; $display("FAIL b2b_gap: got %0d want %0d", last_gap[0], dv + 1); end
        compared++; if (done_cnt[0] != d0 + 2) begin failed++; $display("FAIL b2b_done_count: got %0d want %0d", done_cnt[0], d0 + 2); end
        compared++; if (edge_log[0][(f0 + 1) % 64] != BITS) begin failed++; $display("FAIL b2b_edges2: got %0d want %0d", edge_log[0][(f0 + 1) % 64], BITS); end
    endtask

    task automatic test_busy_ignore();
        int f0, d0;
        logic [4:0]  a;
        logic [15:0] d;
        a  = 5'($urandom_range(0, 31));
        d  = 16'($urandom());
        f0 = frames[0];
        d0 = done_cnt[0];
        send(0, a, d);
        repeat (40) tick();
        compared++; if (ready[0] !== 1'b0) begin failed++; $display("FAIL busy_ready: got %b want 0", ready[0]); end
        addr[0]      = 5'h0A;
        data[0]      = 16'($urandom());
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_frames(0, f0 + 1);
        repeat (300) tick();
        $display("ch0 busy-ignore frame=%h frames=%0d", frame_log[0][f0 % 64], frames[0] - f0);
        compared++; if (frame_log[0][f0 % 64] !== model_frame(a, d)) begin failed++; $display("FAIL busy_frame: got %h want %h", frame_log[0][f0 % 64], model_frame(a, d)); end
        compared++; if (frames[0] != f0 + 1) begin failed++; $display("FAIL busy_frame_count: got %0d want %0d", frames[0] - f0, 1); end
        compared++; if (done_cnt[0] != d0 + 1) begin failed++; $display("FAIL busy_done_count: got %0d want %0d", done_cnt[0] - d0, 1); end
    endtask

    task automatic test_reset_mid();
        int n, d0;
        send(0, 5'($urandom_range(0, 31)), 16'($urandom()));
        n = 0;
        tick();
        while (edges[0] < 10 && n < 2000) begin
            tick();
            n++;
        end
        compared++; if (edges[0] != 10) begin failed++; $display("FAIL reset_mid_edges: got %0d want 10", edges[0]); end
        d0   = done_cnt[0];
        srst = 1'b1;
        @(posedge clk);
        #1;
        compared++; if (cs[0] !== 1'b1)    begin failed++; $display("FAIL reset_mid_cs: got %b want 1", cs[0]); end
        compared++; if (sclk[0] !== 1'b0)  begin failed++; $display("FAIL reset_mid_sclk: got %b want 0", sclk[0]); end
        compared++; if (mosi[0] !== 1'b0)  begin failed++; $display("FAIL reset_mid_mosi: got %b want 0", mosi[0]); end
        compared++; if (ready[0] !== 1'b1) begin failed++; $display("FAIL reset_mid_ready: got %b want 1", ready[0]); end
        compared++; if (busy[0] !== 1'b0)  begin failed++; $display("FAIL reset_mid_busy: got %b want 0", busy[0]); end
        srst = 1'b0;
        repeat (300) tick();
        compared++; if (done_cnt[0] != d0) begin failed++; $display("FAIL reset_mid_done: got %0d pulses want 0", done_cnt[0] - d0); end
        test_frame(0, 5'($urandom_range(0, 31)), 16'($urandom()));
    endtask

    task automatic test_clkdiv2();
        test_frame(1, 5'h12, 16'h8001);
        test_frame(1, 5'($urandom_range(0, 31)), 16'($urandom()));
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            req_valid[i] = 1'b0;
            addr[i]      = 5'd0;
            data[i]      = 16'd0;
        end
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_clkdiv2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
